coax_rx_phase_tracker: RTL

Parametrised successor to the coax receive bit timer. It recovers bit timing from a Manchester-coded coax receive line by locking onto mid-bit transitions. It tracks phase drift within a configurable tolerance window and drops lock after a configurable number of consecutive missing transitions. It sits between the line input stage and the coax receive deserialiser, and supplies both the sample strobe and the sampled bit value.

---
 rtl/coax_rx_phase_tracker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/coax_rx_phase_tracker.sv
// Recovers Manchester bit timing from the coax receive line by locking onto mid-bit transitions.
// Optional build macro COAX_RX_PHASE_TRACKER_GLITCH_FILTER_EN adds a 3-tap majority filter after the synchroniser.
module coax_rx_phase_tracker #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int TOLERANCE      = 2,
  parameter int SAMPLE_OFFSET  = 2,
  parameter int MAX_MISSES     = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic sample,
  output logic bit_value,
  output logic synchronized,
  output logic miss
);

  localparam int PW = $clog2(CLOCKS_PER_BIT + TOLERANCE);
  localparam int MW = $clog2(MAX_MISSES + 1);

  localparam logic [PW-1:0] WIN_LO       = PW'(CLOCKS_PER_BIT - TOLERANCE);
  localparam logic [PW-1:0] WIN_HI       = PW'(CLOCKS_PER_BIT - 1 + TOLERANCE);
  localparam logic [PW-1:0] MISS_RESTART = PW'(TOLERANCE);
  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(SAMPLE_OFFSET);
  localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
  localparam logic [MW-1:0] MISS_LAST    = MW'(MAX_MISSES - 1);
  localparam logic [MW-1:0] MISS_ONE     = MW'(1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic          rx_s;
  logic          rx_d_r;
  logic          edge_s;
  logic          in_window_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_nx_s;
  logic [MW-1:0] miss_cnt_r;
  logic [MW-1:0] miss_cnt_nx_s;
  logic          sample_r;
  logic          sample_nx_s;
  logic          bit_value_r;
  logic          bit_value_nx_s;
  logic          synchronized_r;
  logic          miss_r;
  logic          miss_nx_s;

  // Two-flop synchroniser plus one-cycle history of the conditioned line for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      rx_d_r  <= 1'b0;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      rx_d_r  <= rx_s;
    end
  end

`ifdef COAX_RX_PHASE_TRACKER_GLITCH_FILTER_EN
  logic [1:0] hist_r;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // History of synchronised samples feeding the majority vote
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_r <= 2'b00;
    end else begin
      hist_r <= {hist_r[0], sync2_r};
    end
  end

  // Any single-clock pulse never gets two votes, so it cannot reach the edge detector
  assign rx_s = majority3(sync2_r, hist_r[0], hist_r[1]);
`else
  assign rx_s = sync2_r;
`endif

  assign edge_s      = rx_s ^ rx_d_r;
  assign in_window_s = (phase_r >= WIN_LO) && (phase_r <= WIN_HI);

  // Next-state, phase tracking and output decode
  always_comb begin
    state_nx_s     = state_r;
    phase_nx_s     = phase_r;
    miss_cnt_nx_s  = miss_cnt_r;
    sample_nx_s    = 1'b0;
    bit_value_nx_s = bit_value_r;
    miss_nx_s      = 1'b0;
    case (state_r)
      HUNT: begin
        phase_nx_s    = '0;
        miss_cnt_nx_s = '0;
        if (edge_s) begin
          state_nx_s = LOCKED;
        end else begin
          state_nx_s = HUNT;
        end
      end
      LOCKED: begin
        if (phase_r == SAMPLE_PHASE) begin
          sample_nx_s    = 1'b1;
          bit_value_nx_s = rx_s;
        end else begin
          sample_nx_s    = 1'b0;
        end
        // An edge on the last window cycle still realigns, so it takes priority over the miss
        if (edge_s && in_window_s) begin
          phase_nx_s    = '0;
          miss_cnt_nx_s = '0;
        end else if (phase_r == WIN_HI) begin
          miss_nx_s = 1'b1;
          if (miss_cnt_r == MISS_LAST) begin
            state_nx_s    = HUNT;
            phase_nx_s    = '0;
            miss_cnt_nx_s = '0;
          end else begin
            phase_nx_s    = MISS_RESTART;
            miss_cnt_nx_s = miss_cnt_r + MISS_ONE;
          end
        end else begin
          phase_nx_s = phase_r + PHASE_ONE;
        end
      end
      default: begin
        state_nx_s    = HUNT;
        phase_nx_s    = '0;
        miss_cnt_nx_s = '0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= HUNT;
      phase_r        <= '0;
      miss_cnt_r     <= '0;
      sample_r       <= 1'b0;
      bit_value_r    <= 1'b0;
      synchronized_r <= 1'b0;
      miss_r         <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      phase_r        <= phase_nx_s;
      miss_cnt_r     <= miss_cnt_nx_s;
      sample_r       <= sample_nx_s;
      bit_value_r    <= bit_value_nx_s;
      synchronized_r <= (state_nx_s == LOCKED);
      miss_r         <= miss_nx_s;
    end
  end

  assign sample       = sample_r;
  assign bit_value    = bit_value_r;
  assign synchronized = synchronized_r;
  assign miss         = miss_r;

endmodule
